// File: rtl/frame_pkg.sv
// Shared constants and FSM encoding for the frame reader and its pixel counter.
package frame_pkg;
    localparam int FRAME_W      = 240;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int ADDR_W       = 16;
    localparam int COLOUR_W     = 3;
    localparam int XY_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;
endpackage

// File: rtl/pixel_xy_counter.sv
// Raster position counter: linear pixel index plus column/row, with a last-pixel flag.
module pixel_xy_counter
    import frame_pkg::*;
#(
    parameter int W = frame_pkg::FRAME_W,
    parameter int H = frame_pkg::FRAME_H
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] index,
    output logic [XY_W-1:0]   x,
    output logic [XY_W-1:0]   y,
    output logic              last
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(W * H - 1);
    localparam logic [XY_W-1:0]   X_LAST   = XY_W'(W - 1);

    logic [ADDR_W-1:0] index_q, index_d;
    logic [XY_W-1:0]   x_q, x_d;
    logic [XY_W-1:0]   y_q, y_d;

    // Next position: clear wins; advance never steps past the final pixel.
    always_comb begin
        index_d = index_q;
        x_d     = x_q;
        y_d     = y_q;
        if (clear) begin
            index_d = {ADDR_W{1'b0}};
            x_d     = {XY_W{1'b0}};
            y_d     = {XY_W{1'b0}};
        end else if (advance && (index_q != LAST_IDX)) begin
            index_d = index_q + 16'd1;
            if (x_q == X_LAST) begin
                x_d = {XY_W{1'b0}};
                y_d = y_q + 8'd1;
            end else begin
                x_d = x_q + 8'd1;
                y_d = y_q;
            end
        end else begin
            index_d = index_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_q <= {ADDR_W{1'b0}};
            x_q     <= {XY_W{1'b0}};
            y_q     <= {XY_W{1'b0}};
        end else begin
            index_q <= index_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign index = index_q;
    assign x     = x_q;
    assign y     = y_q;
    assign last  = (index_q == LAST_IDX);
endmodule

// File: rtl/frame_reader.sv
// Walks a frame buffer in raster order, fetching each pixel and handing it to a plotter.
module frame_reader #(
    parameter int FRAME_W  = frame_pkg::FRAME_W,
    parameter int FRAME_H  = frame_pkg::FRAME_H,
    parameter int COLOUR_W = frame_pkg::COLOUR_W
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    output logic [frame_pkg::ADDR_W-1:0] rd_addr,
    input  logic [COLOUR_W-1:0]          rd_data,
    output logic [frame_pkg::XY_W-1:0]   x,
    output logic [frame_pkg::XY_W-1:0]   y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot,
    input  logic                         ready,
    output logic                         busy,
    output logic                         done
);
    import frame_pkg::*;

    state_e              state_q, state_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cnt_clear_s, cnt_advance_s, cnt_last_s;
    logic [ADDR_W-1:0]   index_s;
    logic [XY_W-1:0]     x_s, y_s;

    pixel_xy_counter #(.W(FRAME_W), .H(FRAME_H)) u_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (cnt_clear_s),
        .advance (cnt_advance_s),
        .index   (index_s),
        .x       (x_s),
        .y       (y_s),
        .last    (cnt_last_s)
    );

    // Next state, counter control and colour capture.
    always_comb begin
        state_d       = state_q;
        colour_d      = colour_q;
        cnt_clear_s   = 1'b0;
        cnt_advance_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    cnt_clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                colour_d = rd_data;
                state_d  = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (ready && cnt_last_s) begin
                    state_d = ST_DONE;
                end else if (ready) begin
                    cnt_advance_s = 1'b1;
                    state_d       = ST_FETCH;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_DONE: begin
                cnt_clear_s = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                cnt_clear_s = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
        // Status flags are decoded from the next state so they register in step with it.
        plot_d = (state_d == ST_PRESENT);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            colour_q <= {COLOUR_W{1'b0}};
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign rd_addr = index_s;
    assign x       = x_s;
    assign y       = y_s;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader using a reduced-height frame and a raster-order reference model.
module tb_frame_reader;
    localparam int W = 240;
    localparam int H = 8;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] rd_addr;
    logic [2:0]  rd_data = 3'd0;
    logic [7:0]  x, y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    int checks = 0;
    int errors = 0;

    int tr_x[$], tr_y[$], tr_c[$], tr_a[$];
    int done_cnt, done_cyc, last_cyc, max_addr, hold_bad, stall_cnt, stall_bad;
    bit timed_out;

    frame_reader #(.FRAME_W(W), .FRAME_H(H), .COLOUR_W(3)) dut (
        .clk(clk), .resetn(resetn), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .x(x), .y(y), .colour(colour), .plot(plot), .ready(ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Frame memory: each word holds the low three bits of its address, one cycle of latency.
    always @(posedge clk) rd_data <= rd_addr[2:0];

    // Count transfers that disagree with raster order: pixel k sits at column k%W, row k/W, colour k%8.
    function automatic int frame_mismatches(output int first_bad);
        int bad = 0;
        first_bad = -1;
        for (int k = 0; k < tr_x.size(); k++) begin
            if (tr_x[k] != k % W || tr_y[k] != k / W || tr_c[k] != k % 8 || tr_a[k] != k) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        return bad;
    endfunction

    // Run one frame from an idle DUT, recording every transfer and status event.
    task automatic drive_frame(input int mode, input int stall_at, input bit poke, input bit hold_start);
        int cyc = 0;
        int budget = 12 * N + 50;
        int stall_left = 10;
        logic [7:0] px = 8'd0, py = 8'd0;
        logic [2:0] pc = 3'd0;
        logic [15:0] pa = 16'd0;
        bit pplot = 1'b0, pready = 1'b0;
        tr_x.delete(); tr_y.delete(); tr_c.delete(); tr_a.delete();
        done_cnt = 0; done_cyc = -1; last_cyc = -1; max_addr = 0;
        hold_bad = 0; stall_cnt = 0; stall_bad = 0; timed_out = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        while ((done_cyc < 0 || cyc < done_cyc + 1) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = hold_start ? 1'b1 : (poke && (cyc <= 3 || $urandom_range(0, 3) == 0));
            if (pplot && !pready && (x !== px || y !== py || colour !== pc || rd_addr !== pa || plot !== 1'b1))
                hold_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (plot === 1'b1 && rd_addr == stall_at && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
                stall_cnt++;
                if (x !== 8'(stall_at % W) || y !== 8'(stall_at / W) || colour !== 3'(stall_at % 8))
                    stall_bad++;
            end
            if (plot === 1'b1 && ready) begin
                tr_x.push_back(int'(x)); tr_y.push_back(int'(y));
                tr_c.push_back(int'(colour)); tr_a.push_back(int'(rd_addr));
                last_cyc = cyc;
            end
            pplot = (plot === 1'b1); pready = ready;
            px = x; py = y; pc = colour; pa = rd_addr;
        end
        if (done_cyc < 0) timed_out = 1'b1;
        start = hold_start;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({rd_addr, x, y, colour} !== 35'd0) begin errors++; $display("FAIL reset_data got %h want 0", {rd_addr, x, y, colour}); end
        checks++; if ({plot, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {plot, busy, done}); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if ({busy, plot} !== 2'b00) begin errors++; $display("FAIL idle_no_start got %b want 00", {busy, plot}); end
    endtask

    task automatic test_full_frame();
        int fb, bad;
        drive_frame(0, -1, 1'b0, 1'b0);
        bad = frame_mismatches(fb);
        checks++; if (timed_out) begin errors++; $display("FAIL full_timeout got no done want done"); end
        checks++; if (tr_x.size() != N) begin errors++; $display("FAIL full_count got %0d want %0d", tr_x.size(), N); end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_order got %0d bad (first %0d) want 0", bad, fb); end
        if (tr_x.size() > 241) begin
            checks++; if (tr_x[0] != 0 || tr_y[0] != 0 || tr_c[0] != 0) begin errors++; $display("FAIL first_pixel got %0d,%0d,%0d want 0,0,0", tr_x[0], tr_y[0], tr_c[0]); end
            checks++; if (tr_x[241] != 1 || tr_y[241] != 1 || tr_c[241] != 1) begin errors++; $display("FAIL pixel_241 got %0d,%0d,%0d want 1,1,1", tr_x[241], tr_y[241], tr_c[241]); end
            checks++; if (tr_x[tr_x.size()-1] != W-1 || tr_y[tr_y.size()-1] != H-1) begin errors++; $display("FAIL last_pixel got %0d,%0d want %0d,%0d", tr_x[tr_x.size()-1], tr_y[tr_y.size()-1], W-1, H-1); end
        end
        checks++; if (max_addr != N-1) begin errors++; $display("FAIL max_addr got %0d want %0d", max_addr, N-1); end
        checks++; if (last_cyc != 3*N) begin errors++; $display("FAIL throughput got %0d want %0d", last_cyc, 3*N); end
        checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL done_timing got %0d want %0d", done_cyc, last_cyc + 1); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_once got %0d want 1", done_cnt); end
    endtask

    task automatic test_random_ready();
        int fb, bad;
        drive_frame(1, -1, 1'b0, 1'b0);
        bad = frame_mismatches(fb);
        checks++; if (tr_x.size() != N || bad != 0) begin errors++; $display("FAIL rand_order got %0d xfers %0d bad want %0d 0", tr_x.size(), bad, N); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL rand_hold got %0d want 0", hold_bad); end
        checks++; if (done_cnt != 1 || done_cyc != last_cyc + 1) begin errors++; $display("FAIL rand_done got %0d@%0d want 1@%0d", done_cnt, done_cyc, last_cyc + 1); end
    endtask

    task automatic test_stall();
        int fb, bad, n500 = 0;
        drive_frame(0, 500, 1'b0, 1'b0);
        bad = frame_mismatches(fb);
        foreach (tr_a[k]) if (tr_a[k] == 500) n500++;
        checks++; if (stall_cnt != 10 || stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d cycles %0d bad want 10 0", stall_cnt, stall_bad); end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", hold_bad); end
        checks++; if (n500 != 1) begin errors++; $display("FAIL stall_once got %0d want 1", n500); end
        checks++; if (bad != 0 || tr_x.size() != N) begin errors++; $display("FAIL stall_order got %0d bad want 0", bad); end
        checks++; if (last_cyc != 3*N + 10) begin errors++; $display("FAIL stall_timing got %0d want %0d", last_cyc, 3*N + 10); end
    endtask

    task automatic test_start_ignored();
        int fb, bad;
        drive_frame(0, -1, 1'b1, 1'b0);
        bad = frame_mismatches(fb);
        checks++; if (bad != 0 || tr_x.size() != N) begin errors++; $display("FAIL busy_start got %0d bad %0d xfers want 0 %0d", bad, tr_x.size(), N); end
        checks++; if (last_cyc != 3*N || done_cnt != 1) begin errors++; $display("FAIL busy_start_timing got %0d want %0d", last_cyc, 3*N); end
    endtask

    task automatic test_reset_mid();
        int n = 0, fb, bad;
        bit saw_done = 1'b0;
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!(rd_addr == 16'd1000 && busy === 1'b1 && plot === 1'b0) && n < 4*N) begin
            @(negedge clk); n++;
        end
        checks++; if (n >= 4*N) begin errors++; $display("FAIL mid_timeout got %0d cycles want pixel 1000", n); end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if ({rd_addr, x, y, colour, plot, busy, done} !== 38'd0) begin errors++; $display("FAIL mid_reset got %h want 0", {rd_addr, x, y, colour, plot, busy, done}); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (4) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1; end
        checks++; if (saw_done) begin errors++; $display("FAIL mid_no_done got activity want none"); end
        drive_frame(0, -1, 1'b0, 1'b0);
        bad = frame_mismatches(fb);
        checks++; if (tr_x.size() == 0 || tr_a[0] != 0 || bad != 0) begin errors++; $display("FAIL mid_restart got %0d bad (first %0d) want 0", bad, fb); end
    endtask

    task automatic test_back_to_back();
        int fb, bad;
        drive_frame(0, -1, 1'b0, 1'b1);
        bad = frame_mismatches(fb);
        checks++; if (bad != 0 || tr_x.size() != N) begin errors++; $display("FAIL b2b_order got %0d bad want 0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || rd_addr !== 16'd0 || x !== 8'd0 || y !== 8'd0) begin errors++; $display("FAIL b2b_restart got %b %0d %0d %0d want 1 0 0 0", busy, rd_addr, x, y); end
        repeat (2) @(negedge clk);
        checks++; if (plot !== 1'b1 || x !== 8'd0 || y !== 8'd0 || colour !== 3'd0) begin errors++; $display("FAIL b2b_first got %b %0d %0d %0d want 1 0 0 0", plot, x, y, colour); end
        start = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_ready();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter FRAME_W, default 240, pixels per row.
REQ-002 Parameter FRAME_H, default 240, rows per frame; FRAME_W*FRAME_H = 57600 pixels.
REQ-003 Parameter COLOUR_W, default 3, bits per pixel.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request one full-frame read; sampled only in IDLE.
REQ-007 rd_addr  out  16  frame-memory read address, 0..57599.
REQ-008 rd_data  in  COLOUR_W  memory read data, valid exactly one cycle after rd_addr is presented.
REQ-009 x  out  8  column of presented pixel, 0..FRAME_W-1.
REQ-010 y  out  8  row of presented pixel, 0..FRAME_H-1.
REQ-011 colour  out  COLOUR_W  presented pixel colour.
REQ-012 plot  out  1  valid: x/y/colour hold a pixel for the plotter.
REQ-013 ready  in  1  plotter accepts; transfer occurs on a cycle with plot=1 and ready=1.
REQ-014 busy  out  1  high from start acceptance until done.
REQ-015 done  out  1  one-cycle pulse after last pixel transfer.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, PRESENT, DONE.
REQ-017 IDLE: start=1 -> FETCH with address 0, x=0, y=0; start=0 -> stay.
REQ-018 FETCH: rd_addr SHALL equal the current pixel index; next state WAIT.
REQ-019 WAIT: rd_data SHALL be captured into colour at the end of this cycle; next state PRESENT.
REQ-020 PRESENT: plot=1; x, y, colour SHALL remain stable until transfer.
REQ-021 PRESENT with ready=0 SHALL hold all outputs and state.
REQ-022 PRESENT with ready=1, index < 57599 -> index+1, x+1 (x wraps FRAME_W-1 -> 0 with y+1), then FETCH.
REQ-023 PRESENT with ready=1, index = 57599 -> DONE; index SHALL never reach 57600.
REQ-024 DONE: done=1 for exactly one cycle, index/x/y cleared to 0, then IDLE.
REQ-025 start while busy SHALL be ignored; start held high in IDLE after DONE starts a new frame.
REQ-026 Invariant: rd_addr = y*FRAME_W + x for the pixel in flight; pixel index SHALL use 16-bit unsigned arithmetic.
REQ-027 Throughput: one pixel per 3 cycles when ready is constantly high; full frame = 3*57600 cycles from start acceptance to last transfer.
REQ-028 plot SHALL be 0 in every state except PRESENT; busy SHALL be 1 in FETCH, WAIT, PRESENT, DONE.
REQ-029 ready is ignored outside PRESENT.

Reset
REQ-030 resetn=0 SHALL immediately force IDLE, rd_addr=0, x=0, y=0, colour=0, plot=0, busy=0, done=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no done pulse; next start restarts at pixel 0.

Structure
REQ-032 Shared package frame_pkg SHALL hold FRAME_W, FRAME_H, FRAME_PIXELS (57600), ADDR_W (16), COLOUR_W, and the FSM state encoding.
REQ-033 One sub-module pixel_xy_counter SHALL hold index/x/y with clear and advance inputs and a last-pixel flag.

Verification
REQ-034 Reset then start pulse, ready=1, RAM model data=addr[2:0] -> first transfer x=0,y=0,colour=0; pixel 241 transfers as x=1,y=1,colour=1.
REQ-035 Full frame, ready=1 -> exactly 57600 transfers, last x=239,y=239, rd_addr max 57599, done pulse once 1 cycle after last transfer at 172800 cycles.
REQ-036 ready=0 for 10 cycles in PRESENT at pixel 500 -> x/y/colour/plot held, rd_addr unchanged, pixel 500 transferred once.
REQ-037 start pulsed during FETCH, WAIT and PRESENT -> no restart, index continues incrementing.
REQ-038 resetn asserted asynchronously in WAIT at pixel 1000 -> outputs zero same cycle, no done; restart transfers pixel 0 first.
REQ-039 start held high continuously -> after done, next frame begins from x=0,y=0 with one IDLE cycle between frames.
